// File: rtl/ui_call_ctrl.sv
// Phone UI controller: button conditioning, menu/dial/call FSM, valid/ready command issue.
// Define UI_DEBOUNCE_EN to build per-button debounce counters; otherwise sync + edge detect only.
module ui_call_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MENU_ITEMS      = 4,
  parameter int DIGITS          = 4,
  parameter int RING_TIMEOUT    = 1000
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              enter_i,
  input  logic                              up_i,
  input  logic                              down_i,
  input  logic                              left_i,
  input  logic                              right_i,
  input  logic [3:0]                        digit_in_i,
  input  logic                              init_i,
  input  logic                              incoming_call_i,
  input  logic [2:0]                        inc_command_i,
  input  logic                              cmd_ready_i,
  output logic [2:0]                        cmd_o,
  output logic [4*DIGITS-1:0]               cmd_data_o,
  output logic                              cmd_valid_o,
  output logic [2:0]                        ui_state_o,
  output logic [$clog2(MENU_ITEMS)-1:0]     menu_sel_o,
  output logic [4*DIGITS-1:0]               dial_buf_o,
  output logic [$clog2(DIGITS+1)-1:0]       dial_len_o,
  output logic                              ringing_o
);
  localparam int MSW = $clog2(MENU_ITEMS);
  localparam int LW  = $clog2(DIGITS+1);
  localparam int DW  = 4*DIGITS;
  localparam int RW  = $clog2(RING_TIMEOUT+1);

  localparam logic [2:0] C_DIAL   = 3'd1;
  localparam logic [2:0] C_ANSWER = 3'd2;
  localparam logic [2:0] C_REJECT = 3'd3;
  localparam logic [2:0] C_HANGUP = 3'd4;
  localparam logic [2:0] C_MENU   = 3'd5;

  typedef enum logic [2:0] {
    S_INIT = 3'd0, S_IDLE = 3'd1, S_MENU = 3'd2, S_DIAL = 3'd3,
    S_CALLING = 3'd4, S_RINGING = 3'd5, S_IN_CALL = 3'd6, S_SEND = 3'd7
  } state_t;

  // bit order: 0 enter, 1 left, 2 right, 3 up, 4 down
  logic [4:0] btn_raw, sync1_q, sync2_q, lvl, prev_q, pulse;
  logic       run_q;

  assign btn_raw = {down_i, up_i, right_i, left_i, enter_i};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
      run_q   <= 1'b1;
    end
  end

`ifdef UI_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CW-1:0] db_cnt_q [5];
  logic [4:0]    acc_q;

  // a level is accepted once it has differed from the current one for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] != acc_q[i]) begin
          if (db_cnt_q[i] == CW'(DEBOUNCE_CYCLES-1)) begin
            acc_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end
  assign lvl = acc_q;
`else
  assign lvl = sync2_q;
`endif

  assign pulse = lvl & ~prev_q;

  logic ev_enter, ev_left, ev_right, ev_up, ev_down;
  always_comb begin
    ev_enter = pulse[0];
    ev_left  = pulse[1] & ~pulse[0];
    ev_right = pulse[2] & ~|pulse[1:0];
    ev_up    = pulse[3] & ~|pulse[2:0];
    ev_down  = pulse[4] & ~|pulse[3:0];
  end

  state_t          state_q, state_d, ret_q, ret_d, send_ret;
  logic [MSW-1:0]  menu_q, menu_d;
  logic [DW-1:0]   buf_q, buf_d, data_q, data_d, send_data;
  logic [LW-1:0]   len_q, len_d;
  logic [RW-1:0]   ring_q, ring_d;
  logic [2:0]      cmd_q, cmd_d, send_cmd;
  logic            valid_q, valid_d, send_req, go_ring;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_INIT;
      ret_q   <= S_INIT;
      menu_q  <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      ring_q  <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      menu_q  <= menu_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ring_q  <= ring_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    menu_d    = menu_q;
    buf_d     = buf_q;
    len_d     = len_q;
    ring_d    = ring_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    valid_d   = valid_q;
    send_req  = 1'b0;
    send_cmd  = '0;
    send_data = '0;
    send_ret  = S_IDLE;
    go_ring   = 1'b0;
    if (run_q) begin
      case (state_q)
        S_INIT: if (init_i || ev_enter) state_d = S_IDLE;
        S_IDLE: begin
          if (incoming_call_i) go_ring = 1'b1;
          else if (ev_enter) begin
            state_d = S_MENU;
            menu_d  = '0;
          end
        end
        S_MENU: begin
          if (incoming_call_i) go_ring = 1'b1;
          else if (ev_enter) begin
            if (menu_q == '0) begin
              state_d = S_DIAL;
              len_d   = '0;
              buf_d   = '0;
            end else begin
              send_req            = 1'b1;
              send_cmd            = C_MENU;
              send_data[MSW-1:0]  = menu_q;
              send_ret            = S_MENU;
            end
          end else if (ev_left) state_d = S_IDLE;
          else if (ev_up)   menu_d = (menu_q == '0) ? MSW'(MENU_ITEMS-1) : menu_q - 1'b1;
          else if (ev_down) menu_d = (menu_q == MSW'(MENU_ITEMS-1)) ? '0 : menu_q + 1'b1;
        end
        S_DIAL: begin
          if (incoming_call_i) go_ring = 1'b1;
          else if (ev_right) begin
            if (digit_in_i <= 4'd9 && int'(len_q) < DIGITS) begin
              for (int i = 0; i < DIGITS; i++)
                if (i == DIGITS-1-int'(len_q)) buf_d[4*i +: 4] = digit_in_i;
              len_d = len_q + 1'b1;
            end
          end else if (ev_left) begin
            if (len_q == '0) state_d = S_MENU;
            else begin
              for (int i = 0; i < DIGITS; i++)
                if (i == DIGITS-int'(len_q)) buf_d[4*i +: 4] = 4'd0;
              len_d = len_q - 1'b1;
            end
          end else if (ev_enter && len_q != '0) begin
            send_req  = 1'b1;
            send_cmd  = C_DIAL;
            send_data = buf_q;
            send_ret  = S_CALLING;
          end
        end
        S_CALLING: begin
          if (inc_command_i == 3'd1) state_d = S_IN_CALL;
          else if (inc_command_i == 3'd2) state_d = S_IDLE;
          else if (ev_left) begin
            send_req = 1'b1;
            send_cmd = C_HANGUP;
          end
        end
        S_RINGING: begin
          if (!incoming_call_i) state_d = S_IDLE;
          else if (ev_enter) begin
            send_req = 1'b1;
            send_cmd = C_ANSWER;
            send_ret = S_IN_CALL;
          end else if (ev_left || ring_q == RW'(RING_TIMEOUT-1)) begin
            send_req = 1'b1;
            send_cmd = C_REJECT;
          end else begin
            ring_d = ring_q + 1'b1;
          end
        end
        S_IN_CALL: begin
          if (inc_command_i == 3'd2) state_d = S_IDLE;
          else if (ev_left) begin
            send_req = 1'b1;
            send_cmd = C_HANGUP;
          end
        end
        S_SEND: begin
          if (valid_q && cmd_ready_i) begin
            valid_d = 1'b0;
            cmd_d   = '0;
            data_d  = '0;
            state_d = ret_q;
          end
        end
        default: state_d = S_INIT;
      endcase
      if (go_ring) begin
        state_d = S_RINGING;
        buf_d   = '0;
        len_d   = '0;
        ring_d  = '0;
      end
      if (send_req) begin
        state_d = S_SEND;
        ret_d   = send_ret;
        cmd_d   = send_cmd;
        data_d  = send_data;
        valid_d = 1'b1;
      end
    end
  end

  assign cmd_o       = cmd_q;
  assign cmd_data_o  = data_q;
  assign cmd_valid_o = valid_q;
  assign ui_state_o  = state_q;
  assign menu_sel_o  = menu_q;
  assign dial_buf_o  = buf_q;
  assign dial_len_o  = len_q;
  assign ringing_o   = (state_q == S_RINGING);
endmodule

// File: tb/tb_ui_call_ctrl.sv
// Self-checking bench for ui_call_ctrl: direct state checks plus a command scoreboard.
module tb_ui_call_ctrl;
  localparam int DEB = 4;
  localparam int RT  = 40;
`ifdef UI_DEBOUNCE_EN
  localparam int L = 2 + DEB;
`else
  localparam int L = 2;
`endif
  localparam logic [2:0] S_INIT = 0, S_IDLE = 1, S_MENU = 2, S_DIAL = 3,
                         S_CALLING = 4, S_RINGING = 5, S_IN_CALL = 6, S_SEND = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  btn;           // 0 enter, 1 left, 2 right, 3 up, 4 down
  logic [3:0]  digit_in;
  logic        init, incoming_call, cmd_ready;
  logic [2:0]  inc_command;
  logic [2:0]  cmd, ui_state;
  logic [15:0] cmd_data, dial_buf;
  logic        cmd_valid, ringing;
  logic [1:0]  menu_sel;
  logic [2:0]  dial_len;

  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] sb_q[$];

  ui_call_ctrl #(.DEBOUNCE_CYCLES(DEB), .MENU_ITEMS(4), .DIGITS(4), .RING_TIMEOUT(RT)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .enter_i(btn[0]), .up_i(btn[3]), .down_i(btn[4]), .left_i(btn[1]), .right_i(btn[2]),
    .digit_in_i(digit_in), .init_i(init), .incoming_call_i(incoming_call),
    .inc_command_i(inc_command), .cmd_ready_i(cmd_ready),
    .cmd_o(cmd), .cmd_data_o(cmd_data), .cmd_valid_o(cmd_valid),
    .ui_state_o(ui_state), .menu_sel_o(menu_sel), .dial_buf_o(dial_buf),
    .dial_len_o(dial_len), .ringing_o(ringing)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    repeat (L+2) tick();
    btn[idx] = 1'b0;
    repeat (L+2) tick();
  endtask

  task automatic exp_cmd(input logic [2:0] c, input logic [15:0] d);
    sb_q.push_back({c, d});
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int max, output int n);
    n = 0;
    while (ui_state != target && n < max) begin
      tick();
      n++;
    end
    check_eq(tag, ui_state, target);
  endtask

  // handshake happens on the next rising edge whenever valid && ready is seen here
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_cmd", {13'd0, cmd, cmd_data}, 32'd0);
      end else begin
        logic [18:0] e;
        e = sb_q.pop_front();
        check_eq("sb_cmd", cmd, e[18:16]);
        check_eq("sb_data", cmd_data, e[15:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, vcnt;
    int digs[6] = '{5, 0, 12, 7, 3, 9};
    rst_n = 1'b0; btn = '0; digit_in = '0; init = 1'b0; incoming_call = 1'b0;
    inc_command = '0; cmd_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_state", ui_state, S_INIT);
    check_eq("rst_valid", cmd_valid, 0);
    check_eq("rst_outs", {cmd, cmd_data, menu_sel, dial_len, ringing}, 0);
    check_eq("rst_buf", dial_buf, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("init_hold", ui_state, S_INIT);

    // enter latency and single pulse on hold
    btn[0] = 1'b1;
    repeat (L) tick();
    check_eq("enter_lat_early", ui_state, S_INIT);
    tick();
    check_eq("enter_lat", ui_state, S_IDLE);
    repeat (L+4) tick();
    check_eq("enter_hold_once", ui_state, S_IDLE);
    btn[0] = 1'b0;
    repeat (L+2) tick();

    btn[3] = 1'b1;
    repeat (3) tick();
    btn[3] = 1'b0;
    repeat (L+4) tick();
    check_eq("glitch_sel", menu_sel, 0);
    check_eq("glitch_state", ui_state, S_IDLE);

    press(0);
    check_eq("menu_enter", ui_state, S_MENU);
    check_eq("menu_sel0", menu_sel, 0);
    press(3);
    check_eq("menu_up_wrap", menu_sel, 3);
    press(4);
    press(4);
    check_eq("menu_down_wrap", menu_sel, 1);

    // menu action with ready held low
    cmd_ready = 1'b0;
    exp_cmd(3'd5, 16'd1);
    btn[0] = 1'b1;
    wait_state("wait_send_menu", S_SEND, L+4, n);
    check_eq("send_cmd", cmd, 5);
    check_eq("send_data", cmd_data, 1);
    vcnt = cmd_valid ? 1 : 0;
    repeat (5) begin
      tick();
      vcnt += cmd_valid ? 1 : 0;
    end
    cmd_ready = 1'b1;
    tick();
    check_eq("valid_cycles", vcnt, 6);
    check_eq("send_ret_menu", ui_state, S_MENU);
    check_eq("valid_drop", cmd_valid, 0);
    btn[0] = 1'b0;
    repeat (L+2) tick();

    // enter and down together: only enter acts
    exp_cmd(3'd5, 16'd1);
    btn[0] = 1'b1; btn[4] = 1'b1;
    repeat (L+4) tick();
    btn[0] = 1'b0; btn[4] = 1'b0;
    repeat (L+2) tick();
    check_eq("prio_state", ui_state, S_MENU);
    check_eq("prio_sel", menu_sel, 1);

    press(3);
    check_eq("menu_sel_back0", menu_sel, 0);
    press(0);
    check_eq("dial_enter", ui_state, S_DIAL);
    check_eq("dial_len0", dial_len, 0);
    press(0);
    check_eq("dial_enter_empty", ui_state, S_DIAL);

    foreach (digs[i]) begin
      digit_in = 4'(digs[i]);
      press(2);
    end
    check_eq("dial_buf_full", dial_buf, 16'h5073);
    check_eq("dial_len_full", dial_len, 4);
    press(1);
    check_eq("dial_buf_bs", dial_buf, 16'h5070);
    check_eq("dial_len_bs", dial_len, 3);
    exp_cmd(3'd1, 16'h5070);
    press(0);
    check_eq("calling", ui_state, S_CALLING);
    inc_command = 3'd1;
    tick();
    inc_command = 3'd0;
    check_eq("connected", ui_state, S_IN_CALL);
    exp_cmd(3'd4, 16'd0);
    press(1);
    check_eq("hangup_idle", ui_state, S_IDLE);

    // ring timeout from DIAL
    press(0);
    press(0);
    digit_in = 4'd8;
    press(2);
    check_eq("dial_one", dial_len, 1);
    exp_cmd(3'd3, 16'd0);
    incoming_call = 1'b1;
    wait_state("wait_ring", S_RINGING, 5, n);
    check_eq("ring_len_clr", dial_len, 0);
    check_eq("ring_buf_clr", dial_buf, 0);
    check_eq("ringing_flag", ringing, 1);
    wait_state("wait_reject", S_SEND, RT+10, n);
    check_eq("ring_timeout_cycles", n, RT);
    incoming_call = 1'b0;
    tick();
    check_eq("reject_idle", ui_state, S_IDLE);

    // answer, then remote hangup
    incoming_call = 1'b1;
    wait_state("wait_ring2", S_RINGING, 5, n);
    exp_cmd(3'd2, 16'd0);
    press(0);
    check_eq("answered", ui_state, S_IN_CALL);
    incoming_call = 1'b0;
    inc_command = 3'd2;
    tick();
    inc_command = 3'd0;
    check_eq("remote_hangup", ui_state, S_IDLE);
    check_eq("remote_hangup_valid", cmd_valid, 0);

    incoming_call = 1'b1;
    wait_state("wait_ring3", S_RINGING, 5, n);
    incoming_call = 1'b0;
    tick();
    check_eq("ring_drop_idle", ui_state, S_IDLE);
    check_eq("ring_drop_flag", ringing, 0);

    // reset abort mid-SEND
    press(0);
    press(3);
    cmd_ready = 1'b0;
    btn[0] = 1'b1;
    wait_state("wait_send_abort", S_SEND, L+4, n);
    check_eq("abort_pre_valid", cmd_valid, 1);
    check_eq("abort_pre_data", cmd_data, 3);
    #3 rst_n = 1'b0;
    #1;
    check_eq("abort_valid", cmd_valid, 0);
    check_eq("abort_state", ui_state, S_INIT);
    btn[0] = 1'b0;
    cmd_ready = 1'b1;
    init = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_sync_edge1", ui_state, S_INIT);
    tick();
    check_eq("rst_sync_edge2", ui_state, S_IDLE);

    check_eq("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
